// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Constants shared by the stopwatch display scanner and its segment decoder:
// digit count, per-field upper limits, the ten active-low digit patterns,
// the dash pattern used for out-of-range fields, and a digit-to-pattern
// helper. Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package stopwatch_pkg;

  localparam int NUM_DIGITS  = 6;
  localparam int MAX_MIN_SEC = 59;
  localparam int MAX_MS_10   = 99;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Which input field a digit position belongs to (two digits per field).
  typedef enum logic [1:0] {
    FIELD_MS_10 = 2'd0,
    FIELD_SEC   = 2'd1,
    FIELD_MIN   = 2'd2
  } field_e;

  // Codes 10..15 never come out of a /10 or %10 of an in-range field, so
  // they simply render as an unlit digit.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Turns one decimal digit into its active-low seven-segment pattern, or into
// a dash when the owning field is out of range.
// Ports:
//   digit - 4-bit decimal digit (0..9)
//   dash  - high selects the dash pattern instead of the digit
//   seg   - 7-bit active-low pattern {g,f,e,d,c,b,a}
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  assign seg = dash ? SEG_DASH : digit_to_seg(digit);

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display
// Time-multiplexed driver for a six-digit MM.SS.hh seven-segment display.
// A divider sets how long each digit is lit; each divider tick steps the
// digit index 0..5. The three time fields are snapshotted once per frame
// (as the index wraps 5->0) so a frame never mixes old and new values.
// Ports:
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   min_i   - minutes, binary (6 bits)
//   sec_i   - seconds, binary (6 bits)
//   ms_10_i - hundredths, binary (7 bits)
//   blank   - high turns all digits and the decimal point off
//   an      - active-low one-hot digit enables, bit0 = rightmost digit
//   seg     - active-low segments {g,f,e,d,c,b,a}
//   dp      - active-low decimal point (lit after seconds and minutes)
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int scan_div = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] ms_10_i,
  input  logic       blank,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // A scan_div of 1 still needs a one-bit divider that ticks every cycle.
  localparam int              DIV_W   = (scan_div > 1) ? $clog2(scan_div) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(scan_div - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       idx;
  logic [5:0]       snap_min;
  logic [5:0]       snap_sec;
  logic [6:0]       snap_ms_10;

  field_e     field;
  logic [6:0] field_val;
  logic [6:0] field_max;
  logic       field_bad;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] digit;
  logic [5:0] an_onehot;
  logic [6:0] seg_pattern;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= 3'd0;
      snap_min   <= 6'd0;
      snap_sec   <= 6'd0;
      snap_ms_10 <= 7'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        // Anything at or beyond the last digit (including the unreachable
        // 6/7) falls back to digit 0, starting a new frame.
        if (idx >= LAST_IDX) begin
          idx <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
        // Only the frame-start edge samples the inputs.
        if (idx == LAST_IDX) begin
          snap_min   <= min_i;
          snap_sec   <= sec_i;
          snap_ms_10 <= ms_10_i;
        end
      end
    end
  end

  // Pick the field feeding the current digit; even positions show the ones
  // digit, odd positions the tens digit of that field.
  always_comb begin
    field     = FIELD_MS_10;
    field_val = snap_ms_10;
    field_max = 7'(MAX_MS_10);
    case (idx)
      3'd2, 3'd3: begin
        field     = FIELD_SEC;
        field_val = {1'b0, snap_sec};
        field_max = 7'(MAX_MIN_SEC);
      end
      3'd4, 3'd5: begin
        field     = FIELD_MIN;
        field_val = {1'b0, snap_min};
        field_max = 7'(MAX_MIN_SEC);
      end
      default: begin
        field     = FIELD_MS_10;
        field_val = snap_ms_10;
        field_max = 7'(MAX_MS_10);
      end
    endcase
    field_bad = (field_val > field_max);
    tens      = 4'(field_val / 7'd10);
    ones      = 4'(field_val % 7'd10);
    digit     = idx[0] ? tens : ones;
  end

  seg7_decode u_decode (
    .digit (digit),
    .dash  (field_bad),
    .seg   (seg_pattern)
  );

  // Index values 6/7 shift the one past the top bit, leaving every digit off.
  assign an_onehot = 6'b000001 << idx;

  assign an  = blank ? 6'b111111 : ~an_onehot;
  assign seg = seg_pattern;
  assign dp  = blank ? 1'b1 : !((idx == 3'd2) || (idx == 3'd4));

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display
// Drives the display scanner with directed and random time values and keeps
// a frame-level reference model: after n clock edges out of reset the lit
// digit is (n / scan_div) mod 6, and the fields are sampled every 6*scan_div
// edges. Expected outputs go into a queue; a separate monitor pops and
// compares on each falling edge.
module tb_stopwatch_display;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = SCAN_DIV * 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] min_i;
  logic [5:0] sec_i;
  logic [6:0] ms_10_i;
  logic       blank;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  stopwatch_display #(.scan_div(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .min_i   (min_i),
    .sec_i   (sec_i),
    .ms_10_i (ms_10_i),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       seg_valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sample_no = 0;

  // Reference model state: edges since reset and the per-frame snapshot.
  int edges = 0;
  int snap_min = 0;
  int snap_sec = 0;
  int snap_ms = 0;

  logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};

  function automatic int cur_pos();
    return (edges / SCAN_DIV) % 6;
  endfunction

  // Advance the model by one clock edge, using inputs held across the edge.
  task automatic model_edge();
    if (rst) begin
      edges    = 0;
      snap_min = 0;
      snap_sec = 0;
      snap_ms  = 0;
    end else begin
      edges++;
      if (edges % FRAME == 0) begin
        snap_min = int'(min_i);
        snap_sec = int'(sec_i);
        snap_ms  = int'(ms_10_i);
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t       e;
    int         pos;
    int         v;
    int         lim;
    int         d;
    logic [5:0] onehot;
    pos = cur_pos();
    if (pos < 2) begin
      v = snap_ms;  lim = 99;
    end else if (pos < 4) begin
      v = snap_sec; lim = 59;
    end else begin
      v = snap_min; lim = 59;
    end
    d = (pos % 2 == 1) ? v / 10 : v % 10;
    if (v > lim) e.seg = 7'b0111111;
    else         e.seg = digit_pat[d];
    onehot      = 6'b000001 << pos;
    e.an        = blank ? 6'b111111 : ~onehot;
    e.dp        = blank || !(pos == 2 || pos == 4);
    e.seg_valid = !blank;
    return e;
  endfunction

  // One clock of stimulus: let the edge happen, then apply new inputs and
  // queue what the display should show until the next edge.
  task automatic applyStimulus(input int m, input int s, input int ms,
                               input bit blk, input bit r);
    @(posedge clk);
    model_edge();
    #1;
    min_i   = 6'(m);
    sec_i   = 6'(s);
    ms_10_i = 7'(ms);
    blank   = blk;
    rst     = r;
    if (r) begin
      edges    = 0;
      snap_min = 0;
      snap_sec = 0;
      snap_ms  = 0;
    end
    exp_q.push_back(predict());
  endtask

  task automatic checkOutput(input exp_t e);
    bit ok;
    checks++;
    ok = (an === e.an) && (dp === e.dp) && (!e.seg_valid || seg === e.seg);
    if (!ok) begin
      errors++;
      $display("[TB] FAIL scan sample %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b (seg checked=%0d)",
               sample_no, an, seg, dp, e.an, e.seg, e.dp, e.seg_valid);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        sample_no++;
        checkOutput(e);
      end
    end
  end

  int m_cur, s_cur, ms_cur;
  bit b_cur;

  task automatic runUntilPos(input int pos);
    for (int k = 0; k < FRAME + 1 && cur_pos() != pos; k++) begin
      applyStimulus(m_cur, s_cur, ms_cur, b_cur, 1'b0);
    end
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(m_cur, s_cur, ms_cur, b_cur, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; blank = 1'b0;
    min_i = '0; sec_i = '0; ms_10_i = '0;
    m_cur = 0; s_cur = 0; ms_cur = 0; b_cur = 1'b0;

    // Reset held: rightmost digit showing 0.
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1'b0, 1'b1);

    // 12:34.56 - first frame still shows the zero snapshot, then 6,5,4,3,2,1.
    m_cur = 12; s_cur = 34; ms_cur = 56;
    runCycles(2 * FRAME);

    // Seconds change mid-frame at digit 3; only the next frame reflects it.
    runUntilPos(3);
    s_cur = 35;
    runCycles(FRAME + 2 * SCAN_DIV);

    // Out-of-range seconds dash only their two digits.
    m_cur = 7; s_cur = 60; ms_cur = 99;
    runCycles(2 * FRAME);

    // Blank during digit 3, then resume where the scan would have been.
    m_cur = 45; s_cur = 8; ms_cur = 3;
    runUntilPos(3);
    b_cur = 1'b1;
    runCycles(SCAN_DIV + 3);
    b_cur = 1'b0;
    runCycles(FRAME);

    // Reset between edges while digit 4 is lit.
    runUntilPos(4);
    applyStimulus(m_cur, s_cur, ms_cur, 1'b0, 1'b1);
    applyStimulus(m_cur, s_cur, ms_cur, 1'b0, 1'b1);
    runCycles(FRAME + 5);

    // Random traffic including out-of-range values, blanking and resets.
    for (int k = 0; k < 600; k++) begin
      bit r;
      if ($urandom_range(0, 7) == 0) begin
        m_cur  = $urandom_range(0, 63);
        s_cur  = $urandom_range(0, 63);
        ms_cur = $urandom_range(0, 127);
      end
      if ($urandom_range(0, 15) == 0) b_cur = !b_cur;
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(m_cur, s_cur, ms_cur, b_cur, r);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter scan_div, default 25000; clk cycles per digit dwell.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port min_i  input  6  minutes value from the stopwatch counter, binary.
REQ-005 SHALL have port sec_i  input  6  seconds value, binary.
REQ-006 SHALL have port ms_10_i  input  7  hundredths value, binary.
REQ-007 SHALL have port blank  input  1  high = all digits off.
REQ-008 SHALL have port an  output  6  digit enables, active-low, one-hot-low; bit0 = rightmost digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL run a divider counting 0..scan_div-1, wrapping to 0; tick asserted in the cycle the divider equals scan_div-1.
REQ-012 SHALL hold a 3-bit digit index stepping 0,1,2,3,4,5,0 on each tick; values 6/7 unreachable and, if reached, SHALL step to 0.
REQ-013 SHALL capture min_i, sec_i, ms_10_i into snapshot registers on the tick edge where the index goes 5->0; inputs are ignored at all other edges (no tearing within a frame).
REQ-014 SHALL map digits: idx0 ms_10 ones, idx1 ms_10 tens, idx2 sec ones, idx3 sec tens, idx4 min ones, idx5 min tens.
REQ-015 SHALL split each field by /10 and %10 of the snapshot value.
REQ-016 SHALL, when a snapshot field exceeds its range (min>59, sec>59, ms_10>99), show dash 7'b0111111 on both digits of that field only.
REQ-017 SHALL use digit patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 SHALL drive an = ~(1<<idx) and dp = 0 only at idx 2 and idx 4, else 1.
REQ-019 SHALL make an, seg, dp pure functions of registered index, snapshot and blank; new digit visible in the cycle after the tick edge.
REQ-020 SHALL force an = 6'b111111 and dp = 1 while blank is high, independent of index; scanning and snapshot continue unaffected.
REQ-021 SHALL size the divider to hold scan_div-1; scan_div=1 SHALL tick every cycle.

Reset
REQ-022 SHALL on rst high immediately clear divider, index and snapshot to 0, regardless of clk.
REQ-023 SHALL, with blank low during/after reset, present an=6'b111110, seg=7'b1000000, dp=1.
REQ-024 SHALL, on reset mid-frame, restart at idx0 with a zero snapshot; next capture at the first 5->0 transition.

Structure
REQ-025 SHALL place the ten digit patterns, dash pattern, digit count 6 and field limits 59/99 in shared package stopwatch_pkg.
REQ-026 SHALL instantiate one sub-module seg7_decode (4-bit digit + dash flag -> 7-bit active-low pattern).

Verification
REQ-027 SHALL bench (scan_div=4): reset then hold -> an sequence 111110,111101,111011,110111,101111,011111 each for exactly 4 cycles, repeating.
REQ-028 SHALL bench: min=12, sec=34, ms_10=56 before a 5->0 wrap -> frame shows 6,5,4,3,2,1 (seg 0000010,0010010,0011001,0110000,0100100,1111001), dp low at idx2/idx4 only.
REQ-029 SHALL bench: change sec 34->35 at mid-frame idx3 -> idx3 still shows 3 this frame; idx2 shows 5 from next frame.
REQ-030 SHALL bench: sec=60, min=7, ms_10=99 -> idx2/3 dash, idx4 7, idx5 0, idx0/1 9.
REQ-031 SHALL bench: blank high during idx3 -> an=111111, dp=1; blank low -> scan resumes at the index it would have reached without blanking.
REQ-032 SHALL bench: assert rst between clk edges at idx4 -> outputs reach reset values before the next clk edge.
